// File: rtl/pcs_rx_pkg.sv
// Shared types and helpers for the 64b/66b receive block-sync path.
package pcs_rx_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  typedef enum logic {
    PH_HDR = 1'b0,
    PH_W1  = 1'b1
  } phase_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_rx_block_sync_chk.sv
// Occupancy checker for the receive bit buffer.
module pcs_rx_block_sync_chk #(
  parameter int BUF_WIDTH = 128,
  parameter int OCC_W     = 8
) (
  input logic             i_clk,
  input logic             i_reset_n,
  input logic [OCC_W-1:0] i_occupancy
);

  // Buffer fill including this cycle's appended word must stay below the depth.
  a_occupancy: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (int'(i_occupancy) < BUF_WIDTH));

endmodule

// File: rtl/pcs_rx_lock_fsm.sv
// Block-lock state machine: counts good/bad sync headers and requests a
// one-bit slip whenever alignment is judged wrong.
module pcs_rx_lock_fsm
  import pcs_rx_pkg::*;
#(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_hdr,
  input  logic       i_hdr_strobe,
  output logic       o_slip,
  output logic       o_block_lock
);

  localparam logic [5:0] SH_LAST    = 6'(SH_CNT_MAX - 1);
  localparam logic [4:0] INVLD_LAST = 5'(SH_INVLD_MAX - 1);

  lock_state_t state_q, state_d;
  logic [5:0]  sh_cnt_q, sh_cnt_d;
  logic [4:0]  sh_invld_cnt_q, sh_invld_cnt_d;
  logic        hdr_ok_s;

  // State and window counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q        <= HUNT;
      sh_cnt_q       <= 6'd0;
      sh_invld_cnt_q <= 5'd0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
    end
  end

  // Next-state and slip decision, evaluated once per extracted header.
  always_comb begin
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    o_slip         = 1'b0;
    hdr_ok_s       = hdr_is_valid(i_hdr);
    if (i_hdr_strobe) begin
      case (state_q)
        HUNT: begin
          if (!hdr_ok_s) begin
            o_slip         = 1'b1;
            sh_cnt_d       = 6'd0;
            sh_invld_cnt_d = 5'd0;
          end else if (sh_cnt_q == SH_LAST) begin
            state_d        = LOCKED;
            sh_cnt_d       = 6'd0;
            sh_invld_cnt_d = 5'd0;
          end else begin
            sh_cnt_d = sh_cnt_q + 6'd1;
          end
        end
        LOCKED: begin
          // Too many bad headers wins over a window ending on the same header.
          if (!hdr_ok_s && (sh_invld_cnt_q == INVLD_LAST)) begin
            state_d        = HUNT;
            o_slip         = 1'b1;
            sh_cnt_d       = 6'd0;
            sh_invld_cnt_d = 5'd0;
          end else if (sh_cnt_q == SH_LAST) begin
            sh_cnt_d       = 6'd0;
            sh_invld_cnt_d = 5'd0;
          end else begin
            sh_cnt_d       = sh_cnt_q + 6'd1;
            sh_invld_cnt_d = hdr_ok_s ? sh_invld_cnt_q : sh_invld_cnt_q + 5'd1;
          end
        end
        default: begin
          state_d        = HUNT;
          sh_cnt_d       = 6'd0;
          sh_invld_cnt_d = 5'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign o_block_lock = (state_q == LOCKED);

endmodule

// File: rtl/pcs_rx_block_sync.sv
// Re-frames the PMA word stream into 66-bit blocks (header + two payload words)
// and slips the bit alignment until the lock FSM sees consistent headers.
module pcs_rx_block_sync
  import pcs_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int BUF_WIDTH    = 128
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_data_valid,
  output logic [1:0]            o_rx_hdr,
  output logic                  o_rx_hdr_valid,
  output logic                  o_block_lock
);

  localparam int             CNT_W    = $clog2(BUF_WIDTH);
  localparam logic [CNT_W:0] NEED_HDR = (CNT_W+1)'(DATA_WIDTH + 2);
  localparam logic [CNT_W:0] NEED_W1  = (CNT_W+1)'(DATA_WIDTH);

  logic [BUF_WIDTH-1:0]  buf_q, buf_d, merged_s;
  logic [CNT_W-1:0]      buf_cnt_q, buf_cnt_d;
  logic [CNT_W:0]        need_s, avail_s, drop_s;
  phase_t                phase_q, phase_d;
  logic                  ext_s, hdr_strobe_s, slip_s, slip_req_s;
  logic                  slip_pend_q, slip_pend_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_data_valid_q, rx_data_valid_d;
  logic [1:0]            rx_hdr_q, rx_hdr_d;
  logic                  rx_hdr_valid_q, rx_hdr_valid_d;
  logic                  block_lock_s;

  pcs_rx_lock_fsm #(
    .SH_CNT_MAX  (SH_CNT_MAX),
    .SH_INVLD_MAX(SH_INVLD_MAX)
  ) u_lock_fsm (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_hdr       (buf_q[1:0]),
    .i_hdr_strobe(hdr_strobe_s),
    .o_slip      (slip_s),
    .o_block_lock(block_lock_s)
  );

  pcs_rx_block_sync_chk #(
    .BUF_WIDTH(BUF_WIDTH),
    .OCC_W    (CNT_W + 1)
  ) u_chk (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_occupancy(avail_s)
  );

  // Extraction decision: enough buffered bits for the current phase.
  always_comb begin
    need_s       = (phase_q == PH_HDR) ? NEED_HDR : NEED_W1;
    ext_s        = ({1'b0, buf_cnt_q} >= need_s);
    hdr_strobe_s = ext_s && (phase_q == PH_HDR);
  end

  // Buffer update: append at the fill point, drop extracted bits plus any slip.
  always_comb begin
    merged_s = buf_q;
    avail_s  = {1'b0, buf_cnt_q};
    if (i_rx_valid) begin
      merged_s = buf_q | (BUF_WIDTH'(i_rx_data) << buf_cnt_q);
      avail_s  = {1'b0, buf_cnt_q} + NEED_W1;
    end else begin
      merged_s = buf_q;
    end
    drop_s     = ext_s ? need_s : {(CNT_W+1){1'b0}};
    slip_req_s = slip_s | slip_pend_q;
    // A slip with no spare bit yet waits for the next arriving bit.
    if (slip_req_s && (avail_s > drop_s)) begin
      drop_s      = drop_s + (CNT_W+1)'(1);
      slip_pend_d = 1'b0;
    end else begin
      slip_pend_d = slip_req_s;
    end
    buf_d     = merged_s >> drop_s;
    buf_cnt_d = CNT_W'(avail_s - drop_s);
    if (ext_s) begin
      phase_d = (phase_q == PH_HDR) ? PH_W1 : PH_HDR;
    end else begin
      phase_d = phase_q;
    end
  end

  // Output word selection from the current buffer head.
  always_comb begin
    rx_data_d       = rx_data_q;
    rx_hdr_d        = rx_hdr_q;
    rx_data_valid_d = ext_s;
    rx_hdr_valid_d  = hdr_strobe_s;
    if (hdr_strobe_s) begin
      rx_hdr_d  = buf_q[1:0];
      rx_data_d = buf_q[2 +: DATA_WIDTH];
    end else if (ext_s) begin
      rx_data_d = buf_q[DATA_WIDTH-1:0];
    end else begin
      rx_data_d = rx_data_q;
    end
  end

  // Buffer, phase and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      buf_q           <= {BUF_WIDTH{1'b0}};
      buf_cnt_q       <= {CNT_W{1'b0}};
      phase_q         <= PH_HDR;
      slip_pend_q     <= 1'b0;
      rx_data_q       <= {DATA_WIDTH{1'b0}};
      rx_data_valid_q <= 1'b0;
      rx_hdr_q        <= 2'b00;
      rx_hdr_valid_q  <= 1'b0;
    end else begin
      buf_q           <= buf_d;
      buf_cnt_q       <= buf_cnt_d;
      phase_q         <= phase_d;
      slip_pend_q     <= slip_pend_d;
      rx_data_q       <= rx_data_d;
      rx_data_valid_q <= rx_data_valid_d;
      rx_hdr_q        <= rx_hdr_d;
      rx_hdr_valid_q  <= rx_hdr_valid_d;
    end
  end

  assign o_rx_data       = rx_data_q;
  assign o_rx_data_valid = rx_data_valid_q;
  assign o_rx_hdr        = rx_hdr_q;
  assign o_rx_hdr_valid  = rx_hdr_valid_q;
  assign o_block_lock    = block_lock_s;

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// Scoreboard bench for pcs_rx_block_sync: a block model feeds both the serial
// stimulus and an expected-output queue drained by an independent monitor.
module tb_pcs_rx_block_sync;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_rx_data;
  logic        i_rx_valid;
  logic [31:0] o_rx_data;
  logic        o_rx_data_valid;
  logic [1:0]  o_rx_hdr;
  logic        o_rx_hdr_valid;
  logic        o_block_lock;

  always #5 i_clk = ~i_clk;

  pcs_rx_block_sync #(
    .DATA_WIDTH(32), .SH_CNT_MAX(64), .SH_INVLD_MAX(16), .BUF_WIDTH(128)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .o_rx_data      (o_rx_data),
    .o_rx_data_valid(o_rx_data_valid),
    .o_rx_hdr       (o_rx_hdr),
    .o_rx_hdr_valid (o_rx_hdr_valid),
    .o_block_lock   (o_block_lock)
  );

  typedef struct {
    logic [31:0] data;
    logic        hv;
    logic [1:0]  hdr;
    logic        lock;
  } exp_t;

  exp_t        exp_q[$];
  logic        bitq[$];
  logic [31:0] m_w0[$];
  logic [31:0] m_w1[$];
  logic [1:0]  m_hdr[$];

  int   checks = 0;
  int   errors = 0;
  bit   track_en = 1'b0;
  int   trk_idx = -1;
  int   trk_n = 0;
  bit   fv_seen = 1'b0;
  time  fv_t = 0;
  time  acc_t = 0;
  exp_t mon_e;

  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  task automatic gen_blocks(input int n, input logic [31:0] seed, input int bad_from,
                            input int bad_n, input logic [1:0] bad_hdr);
    logic [31:0] r;
    logic [1:0]  h;
    m_w0.delete(); m_w1.delete(); m_hdr.delete();
    r = seed;
    for (int i = 0; i < n; i++) begin
      r = xs(r); m_w0.push_back(r);
      r = xs(r); m_w1.push_back(r);
      h = r[7] ? 2'b10 : 2'b01;
      if (i >= bad_from && i < bad_from + bad_n) h = bad_hdr;
      m_hdr.push_back(h);
    end
  endtask

  // Lock is expected from block 63 (the 64th header) up to but excluding lock_hi.
  // At lock_hi the slip drops the first bit of word1, so the emitted word1 is
  // shifted by one with the next block's first header bit on top; then stop.
  task automatic push_exp(input int lock_hi);
    exp_t        e;
    logic        lk;
    logic [1:0]  nh;
    logic [31:0] w;
    for (int i = 0; i < m_w0.size(); i++) begin
      lk = (i >= 63) && (i < lock_hi);
      e.data = m_w0[i]; e.hv = 1'b1; e.hdr = m_hdr[i]; e.lock = lk;
      exp_q.push_back(e);
      if (i == lock_hi) begin
        nh = m_hdr[i+1];
        w  = m_w1[i];
        e.data = {nh[0], w[31:1]}; e.hv = 1'b0; e.hdr = 2'b00; e.lock = 1'b0;
        exp_q.push_back(e);
        break;
      end
      e.data = m_w1[i]; e.hv = 1'b0; e.hdr = 2'b00; e.lock = lk;
      exp_q.push_back(e);
    end
  endtask

  task automatic serialize(input int pre_bits);
    logic [1:0]  h;
    logic [31:0] a, b;
    bitq.delete();
    for (int i = 0; i < pre_bits; i++) bitq.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < m_w0.size(); i++) begin
      h = m_hdr[i]; a = m_w0[i]; b = m_w1[i];
      bitq.push_back(h[0]); bitq.push_back(h[1]);
      for (int j = 0; j < 32; j++) bitq.push_back(a[j]);
      for (int j = 0; j < 32; j++) bitq.push_back(b[j]);
    end
    while ((bitq.size() % 32) != 0) bitq.push_back(1'b0);
  endtask

  task automatic drive(input int gap_pct);
    logic [31:0] w;
    int          wc;
    wc = 0;
    while (bitq.size() > 0) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0; i_rx_data = $urandom;
      end else begin
        for (int j = 0; j < 32; j++) w[j] = bitq.pop_front();
        @(posedge i_clk); #1;
        i_rx_valid = 1'b1; i_rx_data = w;
        wc++;
        if (wc == 2) acc_t = $time;
      end
    end
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0; i_rx_data = 32'd0;
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_reset_n = 1'b0; i_rx_valid = 1'b0; i_rx_data = 32'd0;
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    exp_q.delete(); track_en = 1'b0; trk_idx = -1; trk_n = 0; fv_seen = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (8) @(posedge i_clk);
    @(negedge i_clk);
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_data"}, o_rx_data, 32'd0);
    chk({name, "_dvalid"}, {31'd0, o_rx_data_valid}, 32'd0);
    chk({name, "_hdr"}, {30'd0, o_rx_hdr}, 32'd0);
    chk({name, "_hvalid"}, {31'd0, o_rx_hdr_valid}, 32'd0);
    chk({name, "_lock"}, {31'd0, o_block_lock}, 32'd0);
  endtask

  // Monitor: pop the scoreboard per output word; past it, follow locked blocks.
  always @(negedge i_clk) begin
    if (i_reset_n && o_rx_data_valid) begin
      if (!fv_seen) begin
        fv_seen = 1'b1;
        fv_t    = $time;
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_data", o_rx_data, mon_e.data);
        chk("sb_hvalid", {31'd0, o_rx_hdr_valid}, {31'd0, mon_e.hv});
        if (mon_e.hv) chk("sb_hdr", {30'd0, o_rx_hdr}, {30'd0, mon_e.hdr});
        chk("sb_lock", {31'd0, o_block_lock}, {31'd0, mon_e.lock});
      end else if (track_en) begin
        if (!o_block_lock) begin
          trk_idx = -1;
        end else if (o_rx_hdr_valid) begin
          chk("trk_hdr_ok", {31'd0, (o_rx_hdr == 2'b01) || (o_rx_hdr == 2'b10)}, 32'd1);
          if (trk_idx < 0) begin
            for (int k = 0; k < m_w0.size(); k++)
              if (m_w0[k] == o_rx_data && m_hdr[k] == o_rx_hdr) trk_idx = k;
            if (trk_idx < 0) begin
              checks++; errors++;
              $display("FAIL trk_sync actual=%h required=model_block_word0", o_rx_data);
            end
          end else begin
            trk_idx++;
            if (trk_idx >= m_w0.size()) begin
              checks++; errors++;
              $display("FAIL trk_range actual=%0d required=<%0d", trk_idx, m_w0.size());
            end else begin
              chk("trk_w0", o_rx_data, m_w0[trk_idx]);
              chk("trk_hdr", {30'd0, o_rx_hdr}, {30'd0, m_hdr[trk_idx]});
              trk_n++;
            end
          end
        end else if (trk_idx >= 0 && trk_idx < m_w1.size()) begin
          chk("trk_w1", o_rx_data, m_w1[trk_idx]);
          trk_n++;
        end
      end else begin
        checks++; errors++;
        $display("FAIL unexpected_output actual=%h required=none", o_rx_data);
      end
    end
  end

  initial begin
    i_reset_n = 1'b0; i_rx_valid = 1'b0; i_rx_data = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_zero("reset");

    // Aligned stream: lock on the 64th header, content bit-exact, 2-cycle latency.
    do_reset();
    gen_blocks(200, 32'h1234_5678, 0, 0, 2'b00);
    push_exp(100000);
    serialize(0);
    drive(0);
    drain("aligned_drain");
    chk("first_latency", 32'(fv_t - acc_t), 32'd24);
    chk("aligned_lock_end", {31'd0, o_block_lock}, 32'd1);

    // 15 bad headers inside one window must not drop lock.
    do_reset();
    gen_blocks(140, 32'h0BAD_CAFE, 70, 15, 2'b00);
    push_exp(100000);
    serialize(0);
    drive(0);
    drain("tolerance_drain");
    chk("tolerance_lock", {31'd0, o_block_lock}, 32'd1);

    // 16 bad headers drop lock on the 16th with a slip, then realign and relock.
    do_reset();
    gen_blocks(600, 32'hDEAD_BEEF, 70, 16, 2'b11);
    push_exp(85);
    track_en = 1'b1;
    serialize(0);
    drive(0);
    drain("loss_drain");
    chk("loss_relock", {31'd0, o_block_lock}, 32'd1);
    chk("loss_tracked", {31'd0, trk_n > 64}, 32'd1);

    // Start 17 bits off alignment; hunt must find the real block boundary.
    do_reset();
    gen_blocks(400, 32'h0F1E_2D3C, 0, 0, 2'b00);
    track_en = 1'b1;
    serialize(17);
    drive(0);
    drain("mis_drain");
    chk("mis_lock", {31'd0, o_block_lock}, 32'd1);
    chk("mis_tracked", {31'd0, trk_n > 64}, 32'd1);

    // Input gaps must not change content or order.
    do_reset();
    gen_blocks(100, 32'h5566_7788, 0, 0, 2'b00);
    push_exp(100000);
    serialize(0);
    drive(30);
    drain("gaps_drain");
    chk("gaps_lock", {31'd0, o_block_lock}, 32'd1);

    // One-cycle reset while locked with a partial word still buffered.
    @(posedge i_clk); #1 i_reset_n = 1'b0;
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    @(negedge i_clk);
    chk_zero("midreset");
    gen_blocks(80, 32'h9ABC_DEF1, 0, 0, 2'b00);
    push_exp(100000);
    serialize(0);
    drive(0);
    drain("relock_drain");
    chk("relock_lock", {31'd0, o_block_lock}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
